serial_slave: RTL

Serial target for the `serial` controller. Samples an externally supplied serial clock and data line, deserialises words to parallel, and simultaneously serialises reply words back to the controller. It sits on the peripheral side of the same link as `serial`, so a bench can wire one against the other for full-duplex loopback. All logic runs in the main clock domain; the serial clock is treated as data and edge-detected.

---
 rtl/serial_slave.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_slave.sv
// Serial target: edge-detects an external serial clock, deserialises words onto
// out_parallel and serialises reply words from in_parallel. Macro: SERIAL_SLAVE_SYNC_EN.
module serial_slave #(
  parameter int BITS                = 8,
  parameter bit LOWBIT_FIRST        = 1'b1,
  parameter bit SERIAL_CLK_INACTIVE = 1'b1
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_enable,
  input  logic            in_serial_clk,
  input  logic            in_serial,
  output logic            out_serial,
  input  logic [BITS-1:0] in_parallel,
  output logic [BITS-1:0] out_parallel,
  output logic            out_word_finished,
  output logic            out_next_word,
  output logic            out_ready
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [BITS-1:0] tx_word;
  logic [BITS-1:0] rx_word;
  logic [BITS-1:0] rx_next;
  logic            sclk_q;
  logic            sclk_prev;
  logic            data_q;
  logic            lead_edge;
  logic            trail_edge;

`ifdef SERIAL_SLAVE_SYNC_EN
  logic sclk_meta;
  logic data_meta;

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      sclk_meta <= SERIAL_CLK_INACTIVE;
      sclk_q    <= SERIAL_CLK_INACTIVE;
      sclk_prev <= SERIAL_CLK_INACTIVE;
      data_meta <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      sclk_meta <= in_serial_clk;
      sclk_q    <= sclk_meta;
      sclk_prev <= sclk_q;
      data_meta <= in_serial;
      data_q    <= data_meta;
    end
  end
`else
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      sclk_q    <= SERIAL_CLK_INACTIVE;
      sclk_prev <= SERIAL_CLK_INACTIVE;
      data_q    <= 1'b0;
    end else begin
      sclk_q    <= in_serial_clk;
      sclk_prev <= sclk_q;
      data_q    <= in_serial;
    end
  end
`endif

  // Data is delayed by the same number of stages as the clock, so data_q is
  // the value present when the detected edge occurred on the pins.
  assign lead_edge  = (sclk_q != SERIAL_CLK_INACTIVE) && (sclk_prev == SERIAL_CLK_INACTIVE);
  assign trail_edge = (sclk_q == SERIAL_CLK_INACTIVE) && (sclk_prev != SERIAL_CLK_INACTIVE);

  function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] c);
    return LOWBIT_FIRST ? c : CW'(BITS - 1) - c;
  endfunction

  always_comb begin
    rx_next                 = rx_word;
    rx_next[bit_pos(count)] = data_q;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state             <= IDLE;
      count             <= '0;
      tx_word           <= '0;
      rx_word           <= '0;
      out_serial        <= 1'b1;
      out_parallel      <= '0;
      out_word_finished <= 1'b0;
      out_next_word     <= 1'b0;
      out_ready         <= 1'b1;
    end else begin
      out_word_finished <= 1'b0;
      out_next_word     <= 1'b0;
      case (state)
        IDLE: begin
          out_ready  <= 1'b1;
          out_serial <= 1'b1;
          if (in_enable) begin
            tx_word       <= in_parallel;
            out_next_word <= 1'b1;
            out_serial    <= in_parallel[bit_pos(CW'(0))];
            count         <= '0;
            out_ready     <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (!in_enable) begin
            out_serial <= 1'b1;
            out_ready  <= 1'b1;
            count      <= '0;
            state      <= IDLE;
          end else if (trail_edge) begin
            rx_word <= rx_next;
            if (count == CW'(BITS - 1)) begin
              out_parallel      <= rx_next;
              out_word_finished <= 1'b1;
              tx_word           <= in_parallel;
              out_next_word     <= 1'b1;
              out_serial        <= in_parallel[bit_pos(CW'(0))];
              count             <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end else if (lead_edge) begin
            out_serial <= tx_word[bit_pos(count)];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
